// File: rtl/regfile_pkg.sv
// Shared widths and write-request types for the register-file write path.
// Used by regfile_wr_arb and its round-robin arbiter.
package regfile_pkg;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with its last_grant flop.
// REGARB_FIXED_PRIO_EN reduces it to a fixed priority encoder (req[0] wins).
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic       adv
);

`ifdef REGARB_FIXED_PRIO_EN
    logic unused_arb;
    assign unused_arb = ^{clk, reset, adv};

    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0];
        gnt[1] = req[1] & ~req[0];
    end
`else
    logic last_grant;

    // On contention the requester that did not win last time goes next.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (adv) begin
            last_grant <= gnt[1];
        end
    end
`endif

endmodule

// File: rtl/regfile_wr_arb.sv
// Arbitrates ALU (req0) and load (req1) writeback onto the regfile write port.
// REGARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module regfile_wr_arb #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [1:0]        gnt;
    logic              adv;
    logic              wr_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt),
        .adv   (adv)
    );

    assign req0_ready = gnt[0] & reset;
    assign req1_ready = gnt[1] & reset;
    assign adv        = req0_ready | req1_ready;

    assign sel_addr = req1_ready ? req1_addr : req0_addr;
    assign sel_data = req1_ready ? req1_data : req0_data;

    // XZR writes complete the handshake but never reach the port.
    assign wr_en = adv && (sel_addr != ZERO_A);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= wr_en;
            if (wr_en) begin
                wa3 <= sel_addr;
                wd3 <= sel_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Scoreboard bench for regfile_wr_arb with a behavioural regfile model.
// Honours REGARB_FIXED_PRIO_EN in its grant model.
module tb_regfile_wr_arb;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req0_valid = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_data = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_data = '0;
    logic              req1_ready;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [DATA_W-1:0] wd3;

    int checks = 0;
    int passed = 0;
    logic tb_last = 1'b1;
    wr_req_t exp_q[$];
    logic [DATA_W-1:0] rf [32];

    regfile_wr_arb dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .we3        (we3),
        .wa3        (wa3),
        .wd3        (wd3)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we3) begin
            rf[wa3] <= wd3;
        end
    end

    function automatic logic [1:0] exp_gnt(input logic v0, input logic v1);
`ifdef REGARB_FIXED_PRIO_EN
        if (v0) return 2'b01;
        if (v1) return 2'b10;
        return 2'b00;
`else
        if (v0 && v1) return tb_last ? 2'b01 : 2'b10;
        return {v1, v0};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic v0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic v1,
                         input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
    endtask

    task automatic model_xfer(input logic [1:0] g);
        wr_req_t e;
        if (g[0]) begin
            tb_last = 1'b0;
            e.addr = req0_addr; e.data = req0_data;
            if (req0_addr != ADDR_W'(ZERO_REG)) exp_q.push_back(e);
        end else if (g[1]) begin
            tb_last = 1'b1;
            e.addr = req1_addr; e.data = req1_data;
            if (req1_addr != ADDR_W'(ZERO_REG)) exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tb_last = 1'b1;
        exp_q.delete();
        step();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00)
            $display("FAIL reset_ready got=%b want=00", {req1_ready, req0_ready});
        else passed++;
        checks++;
        if (we3 !== 1'b0 || wa3 !== '0 || wd3 !== '0)
            $display("FAIL reset_out got we3=%b wa3=%0d wd3=%0d want 0/0/0", we3, wa3, wd3);
        else passed++;
        step();
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00 || we3 !== 1'b0)
            $display("FAIL reset_hold got rdy=%b we3=%b want 00/0", {req1_ready, req0_ready}, we3);
        else passed++;
        do_reset();
    endtask

    task automatic test_single();
        wr_req_t e;
        logic [1:0] g;
        apply(1, 2, 27, 0, 0, 0);
        g = exp_gnt(1, 0);
        checks++;
        if ({req1_ready, req0_ready} !== g)
            $display("FAIL single_ready got=%b want=%b", {req1_ready, req0_ready}, g);
        else passed++;
        model_xfer(g);
        step();
        apply(0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (we3 !== 1'b1 || wa3 !== e.addr || wd3 !== e.data)
            $display("FAIL single_out got we3=%b wa3=%0d wd3=%0d want 1/%0d/%0d", we3, wa3, wd3, e.addr, e.data);
        else passed++;
        step();
        checks++;
        if (we3 !== 1'b0 || wa3 !== 5'd2 || wd3 !== 64'd27)
            $display("FAIL single_idle got we3=%b wa3=%0d wd3=%0d want 0/2/27", we3, wa3, wd3);
        else passed++;
        checks++;
        if (rf[2] !== 64'd27) $display("FAIL single_rd1 got=%0d want=27", rf[2]);
        else passed++;
    endtask

    task automatic test_contention();
        wr_req_t e;
        logic [1:0] g;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            apply(1, 4, 28, 1, 5, 29);
            g = exp_gnt(1, 1);
            checks++;
            if ({req1_ready, req0_ready} !== g)
                $display("FAIL contend_gnt[%0d] got=%b want=%b", i, {req1_ready, req0_ready}, g);
            else passed++;
            model_xfer(g);
            step();
            e = exp_q.pop_front();
            checks++;
            if (we3 !== 1'b1 || wa3 !== e.addr || wd3 !== e.data)
                $display("FAIL contend_out[%0d] got we3=%b wa3=%0d wd3=%0d want 1/%0d/%0d", i, we3, wa3, wd3, e.addr, e.data);
            else passed++;
        end
        apply(0, 0, 0, 0, 0, 0);
        step();
        checks++;
        if (we3 !== 1'b0) $display("FAIL contend_idle got we3=%b want=0", we3);
        else passed++;
        checks++;
`ifdef REGARB_FIXED_PRIO_EN
        if (rf[4] !== 64'd28 || rf[5] !== 64'd0)
            $display("FAIL contend_rf got x4=%0d x5=%0d want 28/0", rf[4], rf[5]);
`else
        if (rf[4] !== 64'd28 || rf[5] !== 64'd29)
            $display("FAIL contend_rf got x4=%0d x5=%0d want 28/29", rf[4], rf[5]);
`endif
        else passed++;
    endtask

    task automatic test_xzr();
        logic [1:0] g;
        do_reset();
        apply(0, 0, 0, 1, 31, 52);
        g = exp_gnt(0, 1);
        checks++;
        if ({req1_ready, req0_ready} !== g)
            $display("FAIL xzr_ready got=%b want=%b", {req1_ready, req0_ready}, g);
        else passed++;
        model_xfer(g);
        step();
        apply(0, 0, 0, 0, 0, 0);
        checks++;
        if (we3 !== 1'b0 || exp_q.size() != 0)
            $display("FAIL xzr_we3 got we3=%b want=0", we3);
        else passed++;
        step();
        checks++;
        if (rf[31] !== 64'd0) $display("FAIL xzr_rd2 got=%0d want=0", rf[31]);
        else passed++;
    endtask

    task automatic test_same_addr();
        wr_req_t e;
        logic [1:0] g;
        do_reset();
        apply(1, 7, 1, 1, 7, 2);
        g = exp_gnt(1, 1);
        checks++;
        if ({req1_ready, req0_ready} !== g)
            $display("FAIL same_gnt0 got=%b want=%b", {req1_ready, req0_ready}, g);
        else passed++;
        model_xfer(g);
        step();
        apply(0, 7, 1, 1, 7, 2);
        e = exp_q.pop_front();
        checks++;
        if (we3 !== 1'b1 || wa3 !== e.addr || wd3 !== e.data)
            $display("FAIL same_out0 got we3=%b wa3=%0d wd3=%0d want 1/%0d/%0d", we3, wa3, wd3, e.addr, e.data);
        else passed++;
        g = exp_gnt(0, 1);
        checks++;
        if ({req1_ready, req0_ready} !== g)
            $display("FAIL same_gnt1 got=%b want=%b", {req1_ready, req0_ready}, g);
        else passed++;
        model_xfer(g);
        step();
        apply(0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (we3 !== 1'b1 || wa3 !== e.addr || wd3 !== e.data)
            $display("FAIL same_out1 got we3=%b wa3=%0d wd3=%0d want 1/%0d/%0d", we3, wa3, wd3, e.addr, e.data);
        else passed++;
        step();
        checks++;
        if (rf[7] !== 64'd2) $display("FAIL same_rd1 got=%0d want=2", rf[7]);
        else passed++;
    endtask

    task automatic test_reset_mid();
        wr_req_t e;
        logic [1:0] g;
        do_reset();
        apply(1, 4, 28, 1, 5, 29);
        g = exp_gnt(1, 1);
        model_xfer(g);
        step();
        e = exp_q.pop_front();
        checks++;
        if (we3 !== 1'b1 || wa3 !== e.addr)
            $display("FAIL mid_pre got we3=%b wa3=%0d want 1/%0d", we3, wa3, e.addr);
        else passed++;
        reset = 1'b0;
        tb_last = 1'b1;
        exp_q.delete();
        #1;
        checks++;
        if (we3 !== 1'b0 || {req1_ready, req0_ready} !== 2'b00)
            $display("FAIL mid_rst got we3=%b rdy=%b want 0/00", we3, {req1_ready, req0_ready});
        else passed++;
        #1;
        reset = 1'b1;
        #1;
        g = exp_gnt(1, 1);
        checks++;
        if ({req1_ready, req0_ready} !== g || g !== 2'b01)
            $display("FAIL mid_regnt got=%b want=%b", {req1_ready, req0_ready}, g);
        else passed++;
        model_xfer(g);
        step();
        apply(0, 0, 0, 0, 0, 0);
        e = exp_q.pop_front();
        checks++;
        if (we3 !== 1'b1 || wa3 !== e.addr || wd3 !== e.data)
            $display("FAIL mid_out got we3=%b wa3=%0d wd3=%0d want 1/%0d/%0d", we3, wa3, wd3, e.addr, e.data);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_xzr();
        test_same_addr();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
